// File: rtl/mem_writeback_pkg.sv
// Shared definitions for the MIPS writeback stage: load opcodes and the
// state encoding of the two-entry writeback skid queue.
package mem_writeback_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LL  = 6'h30;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } q_state_t;

endpackage

// File: rtl/load_extend.sv
// Combinational writeback data former: chooses the ALU result or the loaded
// word, extracts the addressed little-endian byte/halfword and extends it
// to a full register-width value.
module load_extend #(
  parameter int DATA_W = 32
) (
  input  logic [5:0]        opcode,
  input  logic [1:0]        byte_off,
  input  logic [DATA_W-1:0] mem_word,
  input  logic              mem_to_reg,
  input  logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] wb_data
);
  import mem_writeback_pkg::*;

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Lane selection and sign/zero extension; halfword lane ignores offset bit 0
  always_comb begin
    sel_byte = mem_word[7:0];
    case (byte_off)
      2'd0:    sel_byte = mem_word[7:0];
      2'd1:    sel_byte = mem_word[15:8];
      2'd2:    sel_byte = mem_word[23:16];
      default: sel_byte = mem_word[31:24];
    endcase
    sel_half = byte_off[1] ? mem_word[31:16] : mem_word[15:0];

    wb_data = mem_word;
    if (!mem_to_reg) begin
      wb_data = alu_result;
    end else begin
      case (opcode)
        OP_LB:        wb_data = {{(DATA_W-8){sel_byte[7]}}, sel_byte};
        OP_LBU:       wb_data = {{(DATA_W-8){1'b0}}, sel_byte};
        OP_LH:        wb_data = {{(DATA_W-16){sel_half[15]}}, sel_half};
        OP_LHU:       wb_data = {{(DATA_W-16){1'b0}}, sel_half};
        OP_LW, OP_LL: wb_data = mem_word;
        default:      wb_data = mem_word;
      endcase
    end
  end

endmodule

// File: rtl/mem_writeback.sv
// MIPS writeback stage. Forms the register write (address from RegDst, data
// from ALU or extended load) at accept time and holds it in a 2-entry FIFO
// so the register file can stall without losing instructions. Writes to
// register 0 and non-writing instructions are consumed and dropped.
// Optional statistics counters are built when MEM_WRITEBACK_STATS_EN is
// defined; otherwise wb_count/stall_count are constant zero.
module mem_writeback #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_opcode,
  input  logic [REG_AW-1:0] in_rt,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_reg_dst,
  input  logic              in_reg_write,
  input  logic              in_mem_to_reg,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [1:0]        in_byte_off,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [31:0]       wb_count,
  output logic [31:0]       stall_count
);
  import mem_writeback_pkg::*;

  q_state_t          state;
  logic [REG_AW-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [REG_AW-1:0] tail_addr;
  logic [DATA_W-1:0] tail_data;
  logic [REG_AW-1:0] new_addr;
  logic [DATA_W-1:0] new_data;
  logic              accept;
  logic              enq;
  logic              retire;

  assign new_addr = in_reg_dst ? in_rd : in_rt;

  load_extend #(
    .DATA_W(DATA_W)
  ) u_load_extend (
    .opcode    (in_opcode),
    .byte_off  (in_byte_off),
    .mem_word  (in_mem_data),
    .mem_to_reg(in_mem_to_reg),
    .alu_result(in_alu_result),
    .wb_data   (new_data)
  );

  assign accept = in_valid && in_ready;
  assign enq    = accept && in_reg_write && (new_addr != '0);
  assign retire = wb_valid && wb_ready;

  assign wb_addr = head_addr;
  assign wb_data = head_data;

  // Queue FSM; in_ready/wb_valid are flops updated with each transition
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      wb_valid  <= 1'b0;
      head_addr <= '0;
      head_data <= '0;
      tail_addr <= '0;
      tail_data <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (enq) begin
            head_addr <= new_addr;
            head_data <= new_data;
            wb_valid  <= 1'b1;
            state     <= ONE;
          end
        end
        ONE: begin
          if (enq && retire) begin
            head_addr <= new_addr;
            head_data <= new_data;
          end else if (enq) begin
            tail_addr <= new_addr;
            tail_data <= new_data;
            in_ready  <= 1'b0;
            state     <= FULL;
          end else if (retire) begin
            wb_valid <= 1'b0;
            state    <= EMPTY;
          end
        end
        FULL: begin
          if (retire) begin
            head_addr <= tail_addr;
            head_data <= tail_data;
            in_ready  <= 1'b1;
            state     <= ONE;
          end
        end
        default: begin
          state    <= EMPTY;
          in_ready <= 1'b1;
          wb_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef MEM_WRITEBACK_STATS_EN
  logic [31:0] wb_cnt_q;
  logic [31:0] stall_cnt_q;

  // Retire and stall counters, free-running with natural 32-bit wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (retire) begin
        wb_cnt_q <= wb_cnt_q + 32'd1;
      end
      if (wb_valid && !wb_ready) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign wb_count    = wb_cnt_q;
  assign stall_count = stall_cnt_q;
`else
  assign wb_count    = '0;
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_mem_writeback.sv
// Scoreboard bench for mem_writeback: directed load/ALU vectors push their
// expected register writes into a queue; a monitor pops and compares on
// every retire. Directed checks cover reset, drops, backpressure, streaming
// and reset while full.
module tb_mem_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_opcode;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic        in_reg_dst;
  logic        in_reg_write;
  logic        in_mem_to_reg;
  logic [31:0] in_alu_result;
  logic [31:0] in_mem_data;
  logic [1:0]  in_byte_off;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] wb_count;
  logic [31:0] stall_count;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fails  = 0;
  logic [31:0] model_wb    = 0;
  logic [31:0] model_stall = 0;

  localparam logic [31:0] WORD = 32'h80FF7F01;

  mem_writeback #(.DATA_W(32), .REG_AW(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_opcode    (in_opcode),
    .in_rt        (in_rt),
    .in_rd        (in_rd),
    .in_reg_dst   (in_reg_dst),
    .in_reg_write (in_reg_write),
    .in_mem_to_reg(in_mem_to_reg),
    .in_alu_result(in_alu_result),
    .in_mem_data  (in_mem_data),
    .in_byte_off  (in_byte_off),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .wb_count     (wb_count),
    .stall_count  (stall_count)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Hard time limit so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1, "[TB] time limit");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: pops the scoreboard on each retire and tracks handshake counts
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      model_wb    = 0;
      model_stall = 0;
    end else begin
      if (wb_valid === 1'b1 && wb_ready === 1'b1) begin
        model_wb = model_wb + 1;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("[TB] FAIL unexpected_write: got addr %0d data 0x%08h required no write",
                   wb_addr, wb_data);
        end else begin
          e = exp_q.pop_front();
          checkOutput("sb_wb_addr", {27'b0, wb_addr}, {27'b0, e.addr});
          checkOutput("sb_wb_data", wb_data, e.data);
        end
      end
      if (wb_valid === 1'b1 && wb_ready === 1'b0) begin
        model_stall = model_stall + 1;
      end
    end
  end

  // Drive one instruction, wait (bounded) for in_ready, record its expected write
  task automatic applyStimulus(input logic [5:0] op, input logic [4:0] rt,
                               input logic [4:0] rd, input logic reg_dst,
                               input logic reg_write, input logic mem_to_reg,
                               input logic [31:0] alu, input logic [31:0] mem,
                               input logic [1:0] off, input bit expect_write,
                               input logic [4:0] exp_addr, input logic [31:0] exp_data);
    int waited;
    exp_t e;
    in_opcode     = op;
    in_rt         = rt;
    in_rd         = rd;
    in_reg_dst    = reg_dst;
    in_reg_write  = reg_write;
    in_mem_to_reg = mem_to_reg;
    in_alu_result = alu;
    in_mem_data   = mem;
    in_byte_off   = off;
    in_valid      = 1'b1;
    waited        = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (in_ready !== 1'b1) begin
      n_checks++;
      n_fails++;
      $display("[TB] FAIL accept_timeout: got in_ready %b required 1 within 50 cycles", in_ready);
      in_valid = 1'b0;
    end else if (expect_write) begin
      e.addr = exp_addr;
      e.data = exp_data;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkStats(input string tag);
    logic [31:0] exp_wb;
    logic [31:0] exp_stall;
`ifdef MEM_WRITEBACK_STATS_EN
    exp_wb    = model_wb;
    exp_stall = model_stall;
`else
    exp_wb    = 32'd0;
    exp_stall = 32'd0;
`endif
    checkOutput({tag, "_wb_count"}, wb_count, exp_wb);
    checkOutput({tag, "_stall_count"}, stall_count, exp_stall);
  endtask

  initial begin
    rst           = 1'b1;
    in_valid      = 1'b0;
    in_opcode     = 6'h0;
    in_rt         = 5'd0;
    in_rd         = 5'd0;
    in_reg_dst    = 1'b0;
    in_reg_write  = 1'b0;
    in_mem_to_reg = 1'b0;
    in_alu_result = 32'h0;
    in_mem_data   = 32'h0;
    in_byte_off   = 2'd0;
    wb_ready      = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    checkOutput("rst_wb_addr", {27'b0, wb_addr}, 32'd0);
    checkOutput("rst_wb_data", wb_data, 32'd0);
    checkOutput("rst_wb_count", wb_count, 32'd0);
    checkOutput("rst_stall_count", stall_count, 32'd0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    wb_ready = 1'b1;
    idle(1);

    // LBU, one-cycle latency to wb_valid
    applyStimulus(6'h24, 5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 32'hDEAD0000, WORD, 2'd3,
                  1, 5'd5, 32'h00000080);
    in_valid = 1'b0;
    checkOutput("lat_wb_valid", {31'b0, wb_valid}, 32'd1);
    checkOutput("lat_wb_addr", {27'b0, wb_addr}, 32'd5);
    checkOutput("lat_wb_data", wb_data, 32'h00000080);
    idle(1);

    // Load extraction vectors
    applyStimulus(6'h20, 5'd0, 5'd6, 1'b1, 1'b1, 1'b1, 32'h0, WORD, 2'd3, 1, 5'd6, 32'hFFFFFF80);
    applyStimulus(6'h20, 5'd7, 5'd0, 1'b0, 1'b1, 1'b1, 32'h0, WORD, 2'd1, 1, 5'd7, 32'h0000007F);
    applyStimulus(6'h20, 5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 32'h0, WORD, 2'd2, 1, 5'd8, 32'hFFFFFFFF);
    applyStimulus(6'h21, 5'd0, 5'd12, 1'b1, 1'b1, 1'b1, 32'h0, WORD, 2'd2, 1, 5'd12, 32'hFFFF80FF);
    applyStimulus(6'h21, 5'd0, 5'd13, 1'b1, 1'b1, 1'b1, 32'h0, WORD, 2'd3, 1, 5'd13, 32'hFFFF80FF);
    applyStimulus(6'h25, 5'd0, 5'd14, 1'b1, 1'b1, 1'b1, 32'h0, WORD, 2'd0, 1, 5'd14, 32'h00007F01);
    applyStimulus(6'h25, 5'd0, 5'd15, 1'b1, 1'b1, 1'b1, 32'h0, WORD, 2'd3, 1, 5'd15, 32'h000080FF);
    applyStimulus(6'h23, 5'd16, 5'd0, 1'b0, 1'b1, 1'b1, 32'h0, WORD, 2'd2, 1, 5'd16, 32'h80FF7F01);
    applyStimulus(6'h30, 5'd17, 5'd0, 1'b0, 1'b1, 1'b1, 32'h0, WORD, 2'd1, 1, 5'd17, 32'h80FF7F01);
    applyStimulus(6'h0F, 5'd18, 5'd0, 1'b0, 1'b1, 1'b1, 32'h0, WORD, 2'd3, 1, 5'd18, 32'h80FF7F01);

    // ALU path
    applyStimulus(6'h00, 5'd9, 5'd31, 1'b0, 1'b1, 1'b0, 32'h12345678, WORD, 2'd3,
                  1, 5'd9, 32'h12345678);
    idle(2);

    // Dropped: register 0, then reg_write=0
    applyStimulus(6'h00, 5'd0, 5'd31, 1'b0, 1'b1, 1'b0, 32'h12345678, WORD, 2'd0,
                  0, 5'd0, 32'h0);
    in_valid = 1'b0;
    checkOutput("drop_r0_wb_valid", {31'b0, wb_valid}, 32'd0);
    checkOutput("drop_r0_in_ready", {31'b0, in_ready}, 32'd1);
    applyStimulus(6'h00, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 32'hCAFEF00D, WORD, 2'd0,
                  0, 5'd0, 32'h0);
    in_valid = 1'b0;
    checkOutput("drop_nw_wb_valid", {31'b0, wb_valid}, 32'd0);
    checkOutput("drop_nw_in_ready", {31'b0, in_ready}, 32'd1);
    idle(1);

    // Backpressure: fill both entries, then drain in order
    wb_ready = 1'b0;
    applyStimulus(6'h00, 5'd10, 5'd0, 1'b0, 1'b1, 1'b0, 32'hAAAA0001, WORD, 2'd0,
                  1, 5'd10, 32'hAAAA0001);
    applyStimulus(6'h00, 5'd11, 5'd0, 1'b0, 1'b1, 1'b0, 32'hBBBB0002, WORD, 2'd0,
                  1, 5'd11, 32'hBBBB0002);
    in_valid = 1'b0;
    checkOutput("bp_full_in_ready", {31'b0, in_ready}, 32'd0);
    checkOutput("bp_full_wb_valid", {31'b0, wb_valid}, 32'd1);
    idle(2);
    checkOutput("bp_hold_wb_addr", {27'b0, wb_addr}, 32'd10);
    checkOutput("bp_hold_wb_data", wb_data, 32'hAAAA0001);
    checkOutput("bp_hold_in_ready", {31'b0, in_ready}, 32'd0);
    wb_ready = 1'b1;
    idle(1);
    checkOutput("bp_one_in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("bp_one_wb_addr", {27'b0, wb_addr}, 32'd11);
    idle(1);
    checkOutput("bp_empty_wb_valid", {31'b0, wb_valid}, 32'd0);
    checkStats("bp");

    // Streaming: accept and retire every cycle, state stays ONE
    for (int i = 0; i < 10; i++) begin
      applyStimulus(6'h00, 5'(i + 1), 5'd0, 1'b0, 1'b1, 1'b0, 32'hC0DE0000 + 32'(i), WORD,
                    2'd0, 1, 5'(i + 1), 32'hC0DE0000 + 32'(i));
      checkOutput("stream_in_ready", {31'b0, in_ready}, 32'd1);
      checkOutput("stream_wb_valid", {31'b0, wb_valid}, 32'd1);
    end
    idle(3);
    checkOutput("stream_drained", 32'(exp_q.size()), 32'd0);

    // Reset while FULL discards both entries and clears counters
    wb_ready = 1'b0;
    applyStimulus(6'h00, 5'd20, 5'd0, 1'b0, 1'b1, 1'b0, 32'h20202020, WORD, 2'd0,
                  1, 5'd20, 32'h20202020);
    applyStimulus(6'h00, 5'd21, 5'd0, 1'b0, 1'b1, 1'b0, 32'h21212121, WORD, 2'd0,
                  1, 5'd21, 32'h21212121);
    in_valid = 1'b0;
    checkOutput("rf_full_in_ready", {31'b0, in_ready}, 32'd0);
    idle(2);
    checkStats("rf_pre");
    rst           = 1'b1;
    in_valid      = 1'b1;
    in_rt         = 5'd22;
    in_reg_write  = 1'b1;
    in_alu_result = 32'h22222222;
    exp_q.delete();
    @(posedge clk);
    #1;
    checkOutput("rf_wb_valid", {31'b0, wb_valid}, 32'd0);
    checkOutput("rf_in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("rf_wb_count", wb_count, 32'd0);
    checkOutput("rf_stall_count", stall_count, 32'd0);
    rst      = 1'b0;
    wb_ready = 1'b1;
    idle(5);
    checkOutput("rf_no_stale_valid", {31'b0, wb_valid}, 32'd0);
    checkOutput("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mem_writeback.md
# mem_writeback

Writeback stage of the MIPS datapath. It sits between the data-memory/ALU stage and the register file write port. It picks ALU result or load data, extracts and extends load bytes/halfwords, and resolves the destination register from RegDst. Results are buffered in a 2-entry skid queue so the register file can stall writeback without losing instructions.

## Interface

Parameters:
- `DATA_W`, 32: datapath width.
- `REG_AW`, 5: register address width.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream entry valid.
- `in_ready`  out  1  stage can accept; registered.
- `in_opcode`  in  6  instruction opcode.
- `in_rt`, `in_rd`  in  REG_AW  candidate destinations.
- `in_reg_dst`  in  1  1 selects rd, 0 selects rt.
- `in_reg_write`  in  1  instruction writes a register.
- `in_mem_to_reg`  in  1  1 selects memory data, 0 selects ALU result.
- `in_alu_result`  in  DATA_W  ALU output.
- `in_mem_data`  in  DATA_W  aligned 32-bit memory word.
- `in_byte_off`  in  2  address bits [1:0] of the load.
- `wb_valid`  out  1  register write pending.
- `wb_ready`  in  1  register file accepts the write.
- `wb_addr`  out  REG_AW  destination register.
- `wb_data`  out  DATA_W  fully formed write data.
- `wb_count`, `stall_count`  out  32  statistics (see Configuration).

## Operation

- Accept occurs on `in_valid && in_ready`. Retire occurs on `wb_valid && wb_ready`.
- An accepted entry is enqueued only if `in_reg_write=1` and the resolved address is nonzero. Other accepted entries are consumed and dropped, because register 0 is never written.
- Address: `in_reg_dst ? in_rd : in_rt`.
- Data when `in_mem_to_reg=0`: `in_alu_result`.
- Data when `in_mem_to_reg=1`, by opcode. Little-endian lanes; byte lane = `in_byte_off`; halfword lane = `in_byte_off[1]`, and `in_byte_off[0]` is ignored.
  - 0x20 LB: sign-extend byte.
  - 0x24 LBU: zero-extend byte.
  - 0x21 LH: sign-extend half.
  - 0x25 LHU: zero-extend half.
  - 0x23 LW, 0x30 LL, and any other opcode: full word.
- Data is formed at accept time and stored. The register file always receives a full 32-bit write.
- Queue state machine:
  - States are EMPTY, ONE, FULL.
  - EMPTY goes to ONE on enqueue.
  - ONE goes to FULL on enqueue without retire. It goes to EMPTY on retire without enqueue. It stays ONE on simultaneous enqueue and retire.
  - FULL goes to ONE on retire. No enqueue is possible in FULL.
- `in_ready` = 1 in EMPTY and ONE, 0 in FULL.
- Output order is strict FIFO. The head holds `wb_addr`/`wb_data`, which stay stable while `wb_valid && !wb_ready`.

## Timing

- Latency is 1 cycle: an entry accepted at edge N is presented on `wb_valid` after edge N and can retire at edge N+1.
- No combinational path from `wb_ready` to `in_ready`. `in_ready` reflects state after the current edge.
- In FULL, retire at edge N raises `in_ready` after edge N; a new accept can occur at edge N+1.
- A dropped accept (zero address or `in_reg_write=0`) changes no state and takes one accept slot.
- Reset values: state EMPTY, `in_ready`=1, `wb_valid`=0, `wb_addr`=0, `wb_data`=0, both counters 0.
- Reset asserted mid-operation discards all queued entries on that edge. Inputs are ignored while `rst`=1.

## Configuration

- `MEM_WRITEBACK_STATS_EN` defined:
  - `wb_count` increments on each retire.
  - `stall_count` increments on each cycle with `wb_valid && !wb_ready`.
  - Both are 32-bit and wrap from 0xFFFFFFFF to 0.
- Not defined: both ports are tied to 0 and no counter flops exist.

## Structure

- Shared package holds opcode constants `OP_LB`, `OP_LH`, `OP_LW`, `OP_LBU`, `OP_LHU`, `OP_LL` and the queue state enum.
- Sub-module `load_extend` is combinational. It takes opcode, byte offset, memory word, and `mem_to_reg` + ALU result, and produces `wb_data`. The queue and control stay in `mem_writeback`.

## Test plan

- LBU, opcode 0x24, `in_mem_data`=0x80FF7F01, off=3, rd=5, `reg_dst`=1 -> wb_addr=5, wb_data=0x00000080 one cycle later.
- LB with the same word and off=3 -> wb_data=0xFFFFFF80. LH, off=2 -> 0xFFFF80FF. LHU, off=0 -> 0x00007F01.
- ALU path: `mem_to_reg`=0, alu=0x12345678, rt=9, `reg_dst`=0 -> wb_addr=9, wb_data=0x12345678. Same input with rt=0 -> no `wb_valid`, `in_ready` stays 1.
- Backpressure: `wb_ready`=0, accept A then B -> `in_ready`=0 after B. Raise `wb_ready` -> A retires, `in_ready`=1, then B retires, in order.
- Simultaneous: in ONE with `wb_ready`=1 and a new accept each cycle for 10 cycles -> state stays ONE, 10 writes retire in order.
- Reset during FULL -> after the edge `wb_valid`=0, `in_ready`=1, no stale writes. With `MEM_WRITEBACK_STATS_EN`, prior counts return to 0.
